// File: rtl/cdr_phase_tracker.sv
// rtl/cdr_phase_tracker.sv - bang-bang CDR loop: vote windows, PI loop filter, lock detect with gear shift
module cdr_phase_tracker #(
  parameter int PHASE_W     = 9,
  parameter int FRAC_W      = 4,
  parameter int FREQ_W      = 12,
  parameter int DECIM       = 16,
  parameter int KP_ACQ      = 16,
  parameter int KP_TRK      = 4,
  parameter int KI          = 1,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_CNT    = 32,
  parameter int UNLOCK_CNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vote_valid,
  input  logic              early,
  input  logic              late,
  input  logic              hold,
  output logic [PHASE_W-1:0] phase_code,
  output logic [FREQ_W-1:0]  freq_word,
  output logic              locked,
  output logic              update
);

  localparam int ACC_W  = PHASE_W + FRAC_W;
  localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SUM_W  = CNT_W + 2;
  localparam int QCNT_W = $clog2(LOCK_CNT + 1);
  localparam int NCNT_W = $clog2(UNLOCK_CNT + 1);
  localparam logic signed [FREQ_W:0] FREQ_MAX = (FREQ_W+1)'((1 << (FREQ_W-1)) - 1);
  localparam logic signed [FREQ_W:0] FREQ_MIN = ~FREQ_MAX;

  typedef enum logic {ST_ACQUIRE = 1'b0, ST_TRACK = 1'b1} state_t;

  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [PHASE_W-1:0]       code_q, code_d;
  logic [FREQ_W-1:0]        freq_q, freq_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic                     update_q, update_d;
  state_t                   state_q, state_d;
  logic [QCNT_W-1:0]        quiet_cnt_q, quiet_cnt_d;
  logic [NCNT_W-1:0]        noisy_cnt_q, noisy_cnt_d;

  logic signed [SUM_W-1:0]  vote_s;
  logic signed [SUM_W-1:0]  close_sum;
  logic [SUM_W-1:0]         abs_sum;
  logic                     window_close;
  logic                     quiet;
  logic                     d_pos, d_neg;
  logic [ACC_W-1:0]         kp_v, step_v;
  logic signed [FREQ_W:0]   freq_sum;

  // Vote windowing and the proportional + integral loop filter
  always_comb begin
    acc_d    = acc_q;
    code_d   = code_q;
    freq_d   = freq_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    update_d = 1'b0;
    vote_s   = '0;
    if (!hold && late && !early) begin
      vote_s = SUM_W'(1);
    end else if (!hold && early && !late) begin
      vote_s = {SUM_W{1'b1}};
    end
    close_sum    = sum_q + vote_s;
    window_close = vote_valid && (cnt_q == CNT_W'(DECIM - 1));
    abs_sum      = close_sum[SUM_W-1] ? -close_sum : close_sum;
    quiet        = (abs_sum <= SUM_W'(LOCK_THRESH));
    // Direction is forced to zero in holdover so only the frequency estimate drives phase
    d_pos  = window_close && !hold && !close_sum[SUM_W-1] && (close_sum != '0);
    d_neg  = window_close && !hold && close_sum[SUM_W-1];
    kp_v   = (state_q == ST_ACQUIRE) ? ACC_W'(KP_ACQ) : ACC_W'(KP_TRK);
    step_v = d_pos ? kp_v : (d_neg ? (~kp_v + ACC_W'(1)) : '0);
    freq_sum = $signed({freq_q[FREQ_W-1], freq_q})
             + (d_pos ? (FREQ_W+1)'(KI) : (d_neg ? -((FREQ_W+1)'(KI)) : '0));
    if (vote_valid) begin
      if (window_close) begin
        cnt_d = '0;
        sum_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        sum_d = close_sum;
      end
    end
    if (window_close) begin
      update_d = 1'b1;
      acc_d    = acc_q + step_v + ACC_W'($signed(freq_q));
      code_d   = acc_d[ACC_W-1:FRAC_W];
      if (!hold) begin
        if (freq_sum > FREQ_MAX) begin
          freq_d = FREQ_MAX[FREQ_W-1:0];
        end else if (freq_sum < FREQ_MIN) begin
          freq_d = FREQ_MIN[FREQ_W-1:0];
        end else begin
          freq_d = freq_sum[FREQ_W-1:0];
        end
      end
    end
  end

  // Lock detector: quiet windows promote to TRACK, noisy windows demote to ACQUIRE
  always_comb begin
    state_d     = state_q;
    quiet_cnt_d = quiet_cnt_q;
    noisy_cnt_d = noisy_cnt_q;
    if (window_close && !hold) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (!quiet) begin
            quiet_cnt_d = '0;
          end else if (quiet_cnt_q == QCNT_W'(LOCK_CNT - 1)) begin
            state_d     = ST_TRACK;
            quiet_cnt_d = '0;
          end else begin
            quiet_cnt_d = quiet_cnt_q + QCNT_W'(1);
          end
        end
        default: begin
          if (quiet) begin
            noisy_cnt_d = '0;
          end else if (noisy_cnt_q == NCNT_W'(UNLOCK_CNT - 1)) begin
            state_d     = ST_ACQUIRE;
            noisy_cnt_d = '0;
          end else begin
            noisy_cnt_d = noisy_cnt_q + NCNT_W'(1);
          end
        end
      endcase
    end
  end

  // Loop state registers; reset discards any partial window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      code_q      <= '0;
      freq_q      <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      update_q    <= 1'b0;
      state_q     <= ST_ACQUIRE;
      quiet_cnt_q <= '0;
      noisy_cnt_q <= '0;
    end else begin
      acc_q       <= acc_d;
      code_q      <= code_d;
      freq_q      <= freq_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      update_q    <= update_d;
      state_q     <= state_d;
      quiet_cnt_q <= quiet_cnt_d;
      noisy_cnt_q <= noisy_cnt_d;
    end
  end

  assign phase_code = code_q;
  assign freq_word  = freq_q;
  assign locked     = (state_q == ST_TRACK);
  assign update     = update_q;

endmodule

// File: tb/tb_cdr_phase_tracker.sv
// tb/tb_cdr_phase_tracker.sv - scoreboard bench for cdr_phase_tracker with an integer loop model
module tb_cdr_phase_tracker;
  localparam int ACC_MOD = 1 << 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vote_valid = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic       hold = 1'b0;
  logic [8:0]  phase_code;
  logic [11:0] freq_word;
  logic        locked;
  logic        update;

  cdr_phase_tracker dut (
    .clk(clk), .rst_n(rst_n), .vote_valid(vote_valid), .early(early), .late(late),
    .hold(hold), .phase_code(phase_code), .freq_word(freq_word), .locked(locked),
    .update(update)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int code;
    int freq;
    int lk;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Reference model: plain integer bookkeeping of the loop rules
  int m_cnt, m_sum, m_acc, m_freq, m_trk, m_quiet, m_noisy;
  int prev_code;
  bit wrap_up, wrap_dn;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_acc = 0; m_freq = 0;
    m_trk = 0; m_quiet = 0; m_noisy = 0;
    sbq.delete();
    prev_code = 0; wrap_up = 0; wrap_dn = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input bit l, input bit h);
    int vote, d, kp, mag;
    exp_t x;
    if (!v) return;
    vote = 0;
    if (!h && l && !e) vote = 1;
    if (!h && e && !l) vote = -1;
    m_sum += vote;
    m_cnt++;
    if (m_cnt == 16) begin
      d = (h || m_sum == 0) ? 0 : (m_sum > 0 ? 1 : -1);
      kp = m_trk ? 4 : 16;
      m_acc = (m_acc + d * kp + m_freq) % ACC_MOD;
      if (m_acc < 0) m_acc += ACC_MOD;
      if (!h) begin
        m_freq += d;
        if (m_freq > 2047) m_freq = 2047;
        if (m_freq < -2048) m_freq = -2048;
        mag = (m_sum < 0) ? -m_sum : m_sum;
        if (m_trk == 0) begin
          if (mag <= 2) begin
            m_quiet++;
            if (m_quiet == 32) begin m_trk = 1; m_quiet = 0; end
          end else m_quiet = 0;
        end else begin
          if (mag > 2) begin
            m_noisy++;
            if (m_noisy == 4) begin m_trk = 0; m_noisy = 0; end
          end else m_noisy = 0;
        end
      end
      x.cyc = cyc + 1; x.code = m_acc / 16; x.freq = m_freq; x.lk = m_trk;
      sbq.push_back(x);
      m_cnt = 0;
      m_sum = 0;
    end
  endtask

  task automatic drive(input bit v, input bit e, input bit l, input bit h);
    @(posedge clk);
    #1;
    vote_valid = v; early = e; late = l; hold = h;
    model_step(v, e, l, h);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    vote_valid = 1'b0; early = 1'b0; late = 1'b0; hold = 1'b0;
    #1;
    check("rst_phase_code", int'(phase_code), 0);
    check("rst_freq_word", int'($signed(freq_word)), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_update", int'(update), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: every update pulse must match the oldest expected window result
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (update) begin
          if (sbq.size() == 0) begin
            check("update_unexpected", 1, 0);
          end else begin
            mon_e = sbq.pop_front();
            check("update_cycle", cyc, mon_e.cyc);
            check("phase_code", int'(phase_code), mon_e.code);
            check("freq_word", int'($signed(freq_word)), mon_e.freq);
            check("locked", int'(locked), mon_e.lk);
          end
          if (prev_code >= 448 && int'(phase_code) <= 63) wrap_up = 1;
          if (prev_code <= 63 && int'(phase_code) >= 448) wrap_dn = 1;
          prev_code = int'(phase_code);
        end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          mon_e = sbq.pop_front();
          check("update_missing_at_cycle", 0, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_phase_code", int'(phase_code), 0);
    check("init_freq_word", int'($signed(freq_word)), 0);
    check("init_locked", int'(locked), 0);
    check("init_update", int'(update), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // All-late: codes 1,2,3 and freq 1,2,3
    repeat (48) drive(1, 0, 1, 0);
    idle(2);
    check("late3_phase_code", int'(phase_code), 3);
    check("late3_freq_word", int'($signed(freq_word)), 3);

    // Upward wrap 511 -> 0
    do_reset();
    repeat (16 * 120) drive(1, 0, 1, 0);
    idle(2);
    check("wrap_up_seen", int'(wrap_up), 1);

    // Downward wrap 0 -> 511
    do_reset();
    repeat (16) drive(1, 1, 0, 0);
    idle(2);
    check("early1_phase_code", int'(phase_code), 511);
    check("wrap_dn_seen", int'(wrap_dn), 1);

    // Alternating votes acquire lock; then four late windows at tracking gain drop it
    do_reset();
    for (int i = 0; i < 32 * 16; i++) drive(1, (i % 2) == 0, (i % 2) == 1, 0);
    idle(2);
    check("alt_locked", int'(locked), 1);
    check("alt_phase_code", int'(phase_code), 0);
    repeat (64) drive(1, 0, 1, 0);
    idle(2);
    check("unlock_locked", int'(locked), 0);
    check("unlock_phase_code", int'(phase_code), 1);
    check("unlock_freq_word", int'($signed(freq_word)), 4);

    // Both votes high, then 50% valid with balanced votes
    do_reset();
    repeat (32) drive(1, 1, 1, 0);
    idle(2);
    check("both_phase_code", int'(phase_code), 0);
    for (int i = 0; i < 64; i++) drive((i % 2) == 0, (i % 4) == 0, (i % 4) == 2, 0);
    idle(2);
    check("half_valid_phase_code", int'(phase_code), 0);

    // Holdover after preloading freq_word=5
    do_reset();
    repeat (80) drive(1, 0, 1, 0);
    repeat (64) drive(1, 1'($urandom), 1'($urandom), 1);
    idle(2);
    check("hold_freq_word", int'($signed(freq_word)), 5);
    check("hold_phase_code", int'(phase_code), 6);
    check("hold_locked", int'(locked), 0);

    // Reset at sample 7 of a window with phase_code=3
    do_reset();
    repeat (48) drive(1, 0, 1, 0);
    idle(1);
    check("pre_rst_phase_code", int'(phase_code), 3);
    repeat (7) drive(1, 0, 1, 0);
    do_reset();
    repeat (16) drive(1, 0, 1, 0);
    idle(2);
    check("post_rst_phase_code", int'(phase_code), 1);

    // Randomised votes, qualifiers and holdover
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
    end
    idle(4);
    check("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
